tpuv1_mmio_responder: RTL and testbench

MMIO responder front end for the TPU: decodes the host's single-cycle `addr`/`dataIn`/`r_w` bus into A, B and C storage and a start trigger. On start it streams the stored operands into the systolic core and collects C write-back from the core. It sits between the CCI-P MMIO glue and the systolic array, on the opposite side of the bus from the host-side initiator.

---
 rtl/tpuv1_mmio_responder.sv | 138 +++++++++++++
 tb/tb_tpuv1_mmio_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tpuv1_mmio_responder.sv
// MMIO responder for the TPU: host-visible A/B/C storage, start control,
// operand streaming into the systolic core and C write-back capture.
module tpuv1_mmio_responder #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   parameter int DIM     = 8,
   parameter int ADDRW   = 16,
   parameter int DATAW   = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDRW-1:0]          addr,
   input  logic [DATAW-1:0]          dataIn,
   input  logic                      r_w,
   output logic [DATAW-1:0]          dataOut,
   output logic                      rdValid,
   output logic [DIM*BITS_AB-1:0]    a_col,
   output logic [DIM*BITS_AB-1:0]    b_row,
   output logic                      feed_valid,
   input  logic                      c_wr_en,
   input  logic [$clog2(DIM)-1:0]    c_wr_row,
   input  logic [DIM*BITS_C-1:0]     c_wr_data,
   input  logic                      core_done,
   output logic                      busy
);

   localparam int RW = $clog2(DIM);
   localparam logic [ADDRW-1:0] A_LO = ADDRW'(32'h100);
   localparam logic [ADDRW-1:0] A_HI = ADDRW'(32'h100 + 8 * DIM);
   localparam logic [ADDRW-1:0] B_LO = ADDRW'(32'h200);
   localparam logic [ADDRW-1:0] B_HI = ADDRW'(32'h200 + 8 * DIM);
   localparam logic [ADDRW-1:0] C_LO = ADDRW'(32'h300);
   localparam logic [ADDRW-1:0] C_HI = ADDRW'(32'h300 + 16 * DIM);
   localparam logic [ADDRW-1:0] CTRL = ADDRW'(32'h400);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [RW-1:0]        k_q, k_d;
   logic [DATAW-1:0]     a_mem [DIM];
   logic [DATAW-1:0]     b_mem [DIM];
   logic [2*DATAW-1:0]   c_mem [DIM];

   logic                 a_hit, b_hit, c_hit, ctrl_hit, host_wr;
   logic [RW-1:0]        ab_idx, c_idx;
   logic                 c_hi;

   assign a_hit    = (addr >= A_LO) && (addr < A_HI);
   assign b_hit    = (addr >= B_LO) && (addr < B_HI);
   assign c_hit    = (addr >= C_LO) && (addr < C_HI);
   assign ctrl_hit = (addr[ADDRW-1:3] == CTRL[ADDRW-1:3]);
   assign ab_idx   = addr[3 +: RW];
   assign c_idx    = addr[4 +: RW];
   assign c_hi     = addr[3];
   assign host_wr  = r_w && !busy;

   // Core write is placed last so it overrides a same-row host C write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DIM; i++) begin
            a_mem[i] <= '0;
            b_mem[i] <= '0;
            c_mem[i] <= '0;
         end
      end else begin
         if (host_wr) begin
            if (a_hit) a_mem[ab_idx] <= dataIn;
            if (b_hit) b_mem[ab_idx] <= dataIn;
            if (c_hit) begin
               if (c_hi) c_mem[c_idx][DATAW +: DATAW] <= dataIn;
               else      c_mem[c_idx][0 +: DATAW]     <= dataIn;
            end
         end
         if (c_wr_en) c_mem[c_wr_row] <= c_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      busy       = 1'b0;
      feed_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (host_wr && ctrl_hit) begin
               state_d = FEED;
               k_d     = '0;
            end
         end
         FEED: begin
            busy       = 1'b1;
            feed_valid = 1'b1;
            k_d        = k_q + 1'b1;
            if (k_q == RW'(DIM - 1)) begin
               state_d = DRAIN;
               k_d     = '0;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (core_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // a_col gathers column k across all A rows; b_row is B row k directly.
   always_comb begin
      a_col = '0;
      b_row = '0;
      if (feed_valid) begin
         for (int unsigned i = 0; i < DIM; i++)
            a_col[i*BITS_AB +: BITS_AB] = a_mem[i][k_q*BITS_AB +: BITS_AB];
         b_row = b_mem[k_q];
      end
   end

   always_comb begin
      dataOut = '0;
      if (a_hit)         dataOut = a_mem[ab_idx];
      else if (b_hit)    dataOut = b_mem[ab_idx];
      else if (c_hit)    dataOut = c_hi ? c_mem[c_idx][DATAW +: DATAW]
                                        : c_mem[c_idx][0 +: DATAW];
      else if (ctrl_hit) dataOut = {{(DATAW-1){1'b0}}, busy};
      rdValid = !r_w && (a_hit || b_hit || c_hit || ctrl_hit);
   end

endmodule

// File: tb/tb_tpuv1_mmio_responder.sv
// Directed bench for tpuv1_mmio_responder: address map, feed sequencing,
// C write-back, busy gating and mid-operation reset.
module tb_tpuv1_mmio_responder;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   addr;
   logic [63:0]   dataIn;
   logic          r_w;
   logic [63:0]   dataOut;
   logic          rdValid;
   logic [63:0]   a_col;
   logic [63:0]   b_row;
   logic          feed_valid;
   logic          c_wr_en;
   logic [2:0]    c_wr_row;
   logic [127:0]  c_wr_data;
   logic          core_done;
   logic          busy;

   int n_vec = 0;
   int n_err = 0;

   tpuv1_mmio_responder #(
      .BITS_AB(8), .BITS_C(16), .DIM(8), .ADDRW(16), .DATAW(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .dataIn(dataIn), .r_w(r_w),
      .dataOut(dataOut), .rdValid(rdValid), .a_col(a_col), .b_row(b_row),
      .feed_valid(feed_valid), .c_wr_en(c_wr_en), .c_wr_row(c_wr_row),
      .c_wr_data(c_wr_data), .core_done(core_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      addr   = a;
      dataIn = d;
      r_w    = 1'b1;
      tick();
      r_w    = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [63:0] exp, input logic vld);
      addr = a;
      r_w  = 1'b0;
      #1;
      check({tag, "_data"}, dataOut, exp);
      check({tag, "_vld"}, rdValid, vld);
   endtask

   initial begin
      int fv_cnt;
      rst_n = 1'b0; addr = '0; dataIn = '0; r_w = 1'b0;
      c_wr_en = 1'b0; c_wr_row = '0; c_wr_data = '0; core_done = 1'b0;
      tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_fv", feed_valid, 1'b0);
      check("rst_acol", a_col, 64'h0);
      check("rst_brow", b_row, 64'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) rd("c_rst", 16'h300 + 16'(8 * i), 64'h0, 1'b1);
      rd("unmapped500", 16'h500, 64'h0, 1'b0);

      wr(16'h118, 64'h0807060504030201);
      wr(16'h200, 64'hFFFEFDFCFBFAF9F8);
      rd("a_row3", 16'h118, 64'h0807060504030201, 1'b1);
      rd("b_row0", 16'h200, 64'hFFFEFDFCFBFAF9F8, 1'b1);
      wr(16'h1F8, 64'hDEADBEEFDEADBEEF);
      rd("unmapped1f8", 16'h1F8, 64'h0, 1'b0);
      rd("a_row7_clean", 16'h138, 64'h0, 1'b1);
      rd("a_row0_clean", 16'h100, 64'h0, 1'b1);
      rd("a_row3_keep", 16'h11C, 64'h0807060504030201, 1'b1);

      // A = identity, B row r = all bytes r
      for (int r = 0; r < 8; r++) begin
         wr(16'h100 + 16'(8 * r), 64'h1 << (8 * r));
         wr(16'h200 + 16'(8 * r), 64'h0101010101010101 * 64'(r));
      end
      rd("idle_ctrl", 16'h400, 64'h0, 1'b1);
      wr(16'h400, 64'h0);
      fv_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("feed_v_k%0d", k), feed_valid, 1'b1);
         check($sformatf("feed_a_k%0d", k), a_col, 64'h1 << (8 * k));
         check($sformatf("feed_b_k%0d", k), b_row, 64'h0101010101010101 * 64'(k));
         if (feed_valid) fv_cnt++;
         tick();
      end
      check("feed_end", feed_valid, 1'b0);
      check("drain_acol", a_col, 64'h0);
      check("drain_busy", busy, 1'b1);
      check("feed_cycles", fv_cnt, 8);
      rd("busy_ctrl", 16'h400, 64'h1, 1'b1);

      wr(16'h100, 64'hFFFFFFFFFFFFFFFF);
      wr(16'h400, 64'h0);
      core_done = 1'b0;
      c_wr_en   = 1'b1;
      c_wr_row  = 3'd5;
      c_wr_data = {16'hFFFC, 16'h0004, 16'hFFFD, 16'h0003,
                   16'hFFFE, 16'h0002, 16'hFFFF, 16'h0001};
      tick();
      c_wr_en = 1'b0;
      rd("c5_lo", 16'h350, 64'hFFFE0002FFFF0001, 1'b1);
      rd("c5_hi", 16'h358, 64'hFFFC0004FFFD0003, 1'b1);
      check("busy_before_done", busy, 1'b1);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("busy_after_done", busy, 1'b0);
      rd("idle_ctrl2", 16'h400, 64'h0, 1'b1);
      rd("a_row0_guarded", 16'h100, 64'h1, 1'b1);
      fv_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (feed_valid || busy) fv_cnt++;
         tick();
      end
      check("no_requeued_start", fv_cnt, 0);

      // host and core write the same C row together; core value must stick
      addr = 16'h360; dataIn = 64'h1111111111111111; r_w = 1'b1;
      c_wr_en = 1'b1; c_wr_row = 3'd6;
      c_wr_data = {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};
      tick();
      r_w = 1'b0; c_wr_en = 1'b0;
      rd("c6_lo_core_wins", 16'h360, 64'h5555555555555555, 1'b1);
      rd("c6_hi", 16'h368, 64'hAAAAAAAAAAAAAAAA, 1'b1);
      wr(16'h378, 64'h0000000000001234);
      rd("c7_hi_host", 16'h378, 64'h0000000000001234, 1'b1);
      rd("c7_lo_keep", 16'h370, 64'h0, 1'b1);

      wr(16'h400, 64'h0);
      tick(); tick(); tick(); tick();
      check("k4_acol", a_col, 64'h1 << 32);
      check("k4_brow", b_row, 64'h0404040404040404);
      rst_n = 1'b0;
      #1;
      check("rst_mid_fv", feed_valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_acol", a_col, 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      rd("post_rst_a3", 16'h118, 64'h0, 1'b1);
      rd("post_rst_b2", 16'h210, 64'h0, 1'b1);
      rd("post_rst_c5", 16'h350, 64'h0, 1'b1);
      rd("post_rst_c7", 16'h378, 64'h0, 1'b1);

      wr(16'h100, 64'h00000000000000AB);
      wr(16'h200, 64'h00000000000000CD);
      wr(16'h400, 64'h0);
      check("restart_fv", feed_valid, 1'b1);
      check("restart_acol_k0", a_col, 64'h00000000000000AB);
      check("restart_brow_k0", b_row, 64'h00000000000000CD);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
